// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter and its round-robin picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_arb_state_t;

    localparam logic MEM_DIR_WRITE = 1'b0;
    localparam logic MEM_DIR_READ  = 1'b1;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin selector: first requesting channel searching from last+1.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int CHANNELS = 2
) (
    input  logic [CHANNELS-1:0]              req,
    input  logic [grant_width(CHANNELS)-1:0] last,
    output logic                             valid,
    output logic [grant_width(CHANNELS)-1:0] idx
);

    localparam int GW = grant_width(CHANNELS);

    // cand[k] is the channel examined k+1 positions after last.
    logic [GW-1:0] cand [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cand
            assign cand[gi] = GW'((int'(last) + gi + 1) % CHANNELS);
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest requester wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                valid = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin memory-port arbiter: CHANNELS masters share one external memory port.
// Optional feature: define MEM_ARB_LOCK_EN to add a per-channel lock input that
// keeps the grant on the current channel for back-to-back transactions.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int CHANNELS    = 2,
    parameter int WAIT_STATES = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CHANNELS-1:0]              req,
    input  logic [CHANNELS-1:0]              dir,
    input  logic [CHANNELS*ADDR_WIDTH-1:0]   addr,
    input  logic [CHANNELS*WIDTH-1:0]        wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic [CHANNELS-1:0]              lock,
`endif
    output logic [CHANNELS-1:0]              ack,
    output logic [WIDTH-1:0]                 rdata,
    output logic                             busy,
    output logic [grant_width(CHANNELS)-1:0] grant_id,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [WIDTH-1:0]                 mem_wdata,
    output logic                             mem_we,
    output logic                             mem_re,
    input  logic [WIDTH-1:0]                 mem_rdata,
    input  logic                             mem_ready
);

    localparam int GW = grant_width(CHANNELS);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_STATES);

    mem_arb_state_t state, state_next;
    logic [GW-1:0]  last;
    logic [CW-1:0]  cnt;
    logic           dir_q;
    logic           pick_valid;
    logic [GW-1:0]  pick_idx;
    logic           use_lock;
    logic           win_valid;
    logic [GW-1:0]  win_idx;
    logic [CHANNELS-1:0] ack_next;
    logic           busy_next;
    logic           we_next;
    logic           re_next;

    rr_picker #(.CHANNELS(CHANNELS)) u_picker (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef MEM_ARB_LOCK_EN
    // High only in the IDLE cycle right after a DONE whose channel asked to keep the bus.
    logic lock_hold;

    // Remember the lock request of the channel being acknowledged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_hold <= 1'b0;
        end else begin
            lock_hold <= (state == DONE) && lock[grant_id];
        end
    end

    assign use_lock = lock_hold && req[grant_id];
`else
    assign use_lock = 1'b0;
`endif

    assign win_valid = use_lock || pick_valid;
    assign win_idx   = use_lock ? grant_id : pick_idx;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; mem_ready only matters once the wait counter is exhausted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_valid) state_next = ACCESS;
            ACCESS:  if ((cnt == '0) && mem_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state.
    always_comb begin
        ack_next  = '0;
        busy_next = (state_next != IDLE);
        we_next   = 1'b0;
        re_next   = 1'b0;
        if (state_next == ACCESS) begin
            if (state == IDLE) begin
                we_next = (dir[win_idx] == MEM_DIR_WRITE);
                re_next = (dir[win_idx] == MEM_DIR_READ);
            end else begin
                we_next = (dir_q == MEM_DIR_WRITE);
                re_next = (dir_q == MEM_DIR_READ);
            end
        end
        if ((state == ACCESS) && (state_next == DONE)) begin
            ack_next[grant_id] = 1'b1;
        end
    end

    // Datapath and output registers: latch the winner, count wait states, capture read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack       <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            last      <= GW'(CHANNELS - 1);
            cnt       <= '0;
            dir_q     <= MEM_DIR_WRITE;
        end else begin
            ack    <= ack_next;
            busy   <= busy_next;
            mem_we <= we_next;
            mem_re <= re_next;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant_id  <= win_idx;
                        if (!use_lock) last <= win_idx;
                        cnt       <= CNT_LOAD;
                        dir_q     <= dir[win_idx];
                        mem_addr  <= addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        mem_wdata <= wdata[win_idx*WIDTH +: WIDTH];
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (mem_ready && (dir_q == MEM_DIR_READ)) begin
                        rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (CHANNELS=2, WAIT_STATES=1).
module tb_mem_arbiter;

    localparam int CH = 2;
    localparam int W  = 8;
    localparam int AW = 16;
    localparam int WS = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [CH-1:0]   req;
    logic [CH-1:0]   dir;
    logic [CH*AW-1:0] addr;
    logic [CH*W-1:0] wdata;
    logic [CH-1:0]   ack;
    logic [W-1:0]    rdata;
    logic            busy;
    logic [0:0]      grant_id;
    logic [AW-1:0]   mem_addr;
    logic [W-1:0]    mem_wdata;
    logic            mem_we;
    logic            mem_re;
    logic [W-1:0]    mem_rdata;
    logic            mem_ready;
`ifdef MEM_ARB_LOCK_EN
    logic [CH-1:0]   lock;
`endif

    mem_arbiter #(
        .WIDTH(W), .ADDR_WIDTH(AW), .CHANNELS(CH), .WAIT_STATES(WS)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .dir(dir), .addr(addr), .wdata(wdata),
`ifdef MEM_ARB_LOCK_EN
        .lock(lock),
`endif
        .ack(ack), .rdata(rdata), .busy(busy), .grant_id(grant_id),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction on one channel; stall = extra cycles mem_ready stays low at counter 0.
    task automatic do_txn(input string name, input int ch, input logic rd,
                          input logic [15:0] a, input logic [7:0] d, input int stall,
                          input logic [7:0] mem_val, input logic [7:0] exp_rdata);
        int lat;
        int strobes;
        logic [1:0] ack_seen;
        logic bus_ok;
        lat = 0; strobes = 0; ack_seen = '0; bus_ok = 1'b1;
        req = '0;
        req[ch] = 1'b1;
        dir[ch] = rd;
        addr[ch*AW +: AW] = a;
        wdata[ch*W +: W] = d;
        mem_ready = (stall == 0);
        mem_rdata = (stall == 0) ? mem_val : 8'hEE;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (stall > 0 && cyc == WS + 1 + stall) begin
                mem_ready = 1'b1;
                mem_rdata = mem_val;
            end
            if (mem_re || mem_we) begin
                strobes++;
                if ((rd && !mem_re) || (!rd && !mem_we) || (mem_re && mem_we) ||
                    (mem_addr != a) || (!rd && mem_wdata != d))
                    bus_ok = 1'b0;
            end
            if (ack != '0) begin
                ack_seen = ack;
                lat = cyc;
                req = '0;
                break;
            end
        end
        $display("txn %s ch=%0d rd=%0d addr=0x%0h ack=%b latency=%0d strobes=%0d rdata=0x%0h",
                 name, ch, rd, a, ack_seen, lat, strobes, rdata);
        check({name, "_latency"}, lat, WS + 2 + stall);
        check({name, "_strobes"}, strobes, WS + 1 + stall);
        check({name, "_ack"}, ack_seen, 2'b01 << ch);
        check({name, "_bus"}, bus_ok, 1'b1);
        check({name, "_rdata"}, rdata, exp_rdata);
        check({name, "_grant"}, grant_id, ch);
        @(negedge clk);
        check({name, "_ack_pulse"}, ack, 2'b00);
        check({name, "_idle_busy"}, busy, 1'b0);
        mem_ready = 1'b1;
    endtask

    initial begin
        int k;
        int prev;
        reset = 1'b0; req = '0; dir = '0; addr = '0; wdata = '0;
        mem_rdata = '0; mem_ready = 1'b1;
`ifdef MEM_ARB_LOCK_EN
        lock = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_we", mem_we, 0);
        check("rst_re", mem_re, 0);
        reset = 1'b1;
        @(negedge clk);

        do_txn("rd0", 0, 1'b1, 16'h1234, 8'h00, 0, 8'hA5, 8'hA5);
        do_txn("wr1", 1, 1'b0, 16'h00FF, 8'h5A, 0, 8'h77, 8'hA5);

        // Contention: both channels hold req; grants alternate, acks WS+3 apart.
        req = 2'b11; dir = 2'b11; addr = {16'h0200, 16'h0100}; mem_rdata = 8'h11;
        k = 0; prev = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (ack != '0) begin
                $display("txn contention ack=%b grant=%0d cycle=%0d", ack, grant_id, cyc);
                check("cont_ack", ack, (k % 2 == 0) ? 2'b01 : 2'b10);
                if (k > 0) check("cont_spacing", cyc - prev, WS + 3);
                prev = cyc;
                k++;
                if (k == 4) begin
                    req = '0;
                    break;
                end
            end
        end
        check("cont_count", k, 4);
        repeat (2) @(negedge clk);

        do_txn("stall", 0, 1'b1, 16'h0042, 8'h00, 3, 8'h3C, 8'h3C);

        // Asynchronous reset in the middle of an ACCESS.
        req = 2'b01; dir[0] = 1'b0; addr[AW-1:0] = 16'h0300; wdata[W-1:0] = 8'h99;
        @(negedge clk);
        check("mid_we", mem_we, 1);
        check("mid_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_we", mem_we, 0);
        check("arst_busy", busy, 0);
        check("arst_rdata", rdata, 0);
        req = '0;
        @(negedge clk);
        check("arst_ack", ack, 0);
        reset = 1'b1;
        @(negedge clk);
        req = 2'b11; dir = 2'b11;
        k = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (ack != '0) begin
                $display("txn post_reset ack=%b cycle=%0d", ack, cyc);
                check("post_reset_grant", ack, 2'b01);
                k = 1;
                req = '0;
                break;
            end
        end
        check("post_reset_seen", k, 1);
        repeat (2) @(negedge clk);

`ifdef MEM_ARB_LOCK_EN
        // ch1 locks the bus for three transactions, then releases it.
        lock = 2'b10; req = 2'b11; dir = 2'b11;
        k = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (ack != '0) begin
                $display("txn lock ack=%b cycle=%0d", ack, cyc);
                check("lock_ack", ack, (k < 3) ? 2'b10 : 2'b01);
                k++;
                if (k == 3) lock = '0;
                if (k == 4) begin
                    req = '0;
                    break;
                end
            end
        end
        check("lock_count", k, 4);
        repeat (2) @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
